// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM access controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } sram_state_e;

  localparam int SRAM_DW             = 16;
  localparam int DEFAULT_ADDR_OFFSET = 1024;

endpackage

// File: rtl/sram_wait_counter.sv
// 4-bit loadable down-counter with a zero flag; times one half-word phase.
module sram_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       en_i,
  input  logic [3:0] load_val_i,
  output logic       zero_o
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == 4'd0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Splits 32-bit MEM-stage accesses into two timed 16-bit SRAM phases.
// Define SRAM_CTRL_STATS_EN to add the stall_cycles / access_count outputs.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_OFFSET = DEFAULT_ADDR_OFFSET,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_wdata,
  input  logic [SRAM_DW-1:0] sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n
`ifdef SRAM_CTRL_STATS_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [15:0]        access_count
`endif
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  sram_state_e          state_q, state_d;
  logic [SRAM_AW-2:0]   word_q;
  logic [31:0]          wdata_q;
  logic                 is_wr_q;
  logic [31:0]          rdata_q;

  logic                 req;
  logic                 cnt_load, cnt_en, cnt_zero;
  logic                 latch, cap_lo, cap_hi;
  logic [31:0]          offs;
  logic [SRAM_AW-2:0]   word_idx;
  logic                 unused_offs;

  assign req = mem_r_en | mem_w_en;

  // Upper address bits beyond the SRAM range wrap silently.
  assign offs        = address - 32'(ADDR_OFFSET);
  assign word_idx    = offs[SRAM_AW:2];
  assign unused_offs = ^offs;

  sram_wait_counter u_wait (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .en_i       (cnt_en),
    .load_val_i (WAIT_LOAD),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    latch    = 1'b0;
    cap_lo   = 1'b0;
    cap_hi   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d  = S_LOW;
          cnt_load = 1'b1;
          latch    = 1'b1;
        end
      end
      S_LOW: begin
        if (cnt_zero) begin
          state_d  = S_HIGH;
          cnt_load = 1'b1;
          cap_lo   = !is_wr_q;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_zero) begin
          state_d = S_DONE;
          cap_hi  = !is_wr_q;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        word_q  <= word_idx;
        wdata_q <= wdata;
        is_wr_q <= mem_w_en;
      end
      if (cap_lo) rdata_q[15:0]  <= sram_rdata;
      if (cap_hi) rdata_q[31:16] <= sram_rdata;
    end
  end

  // Bus is decoded from state so a reset edge returns it idle immediately.
  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    case (state_q)
      S_LOW: begin
        sram_addr = {word_q, 1'b0};
        if (is_wr_q) begin
          sram_we_n  = 1'b0;
          sram_wdata = wdata_q[15:0];
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      S_HIGH: begin
        sram_addr = {word_q, 1'b1};
        if (is_wr_q) begin
          sram_we_n  = 1'b0;
          sram_wdata = wdata_q[31:16];
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign ready = ((state_q == S_IDLE) && !req) || (state_q == S_DONE);
  assign rdata = rdata_q;

`ifdef SRAM_CTRL_STATS_EN
  logic [31:0] stall_q;
  logic [15:0] acc_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      acc_q   <= '0;
    end else begin
      if (!ready && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if (state_q == S_DONE) acc_q <= acc_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign access_count = acc_q;
`endif

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Randomized self-checking bench for sram_access_ctrl with an SRAM device model.
module tb_sram_access_ctrl;

  localparam int W   = 2;
  localparam int OFF = 1024;
  localparam int AW  = 18;
  localparam int MEM_WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_r_en, mem_w_en;
  logic [31:0]   address, wdata;
  logic [31:0]   rdata;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_wdata, sram_rdata;
  logic          sram_we_n, sram_oe_n;
`ifdef SRAM_CTRL_STATS_EN
  logic [31:0]   stall_cycles;
  logic [15:0]   access_count;
`endif

  sram_access_ctrl #(.WAIT_CYCLES(W), .ADDR_OFFSET(OFF), .SRAM_AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
`ifdef SRAM_CTRL_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .access_count (access_count)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- SRAM device and monitors ----------------
  logic [15:0] dev_mem [0:MEM_WORDS-1] = '{default: 16'h0};
  logic [15:0] exp_mem [0:MEM_WORDS-1] = '{default: 16'h0};
  int          strobe_cnt   = 0;
  int          ready_lo_cnt = 0;

  assign sram_rdata = sram_oe_n ? 16'h0 : dev_mem[sram_addr];

  always @(posedge clk) begin
    if (!sram_we_n) begin
      dev_mem[sram_addr] <= sram_wdata;
      strobe_cnt         <= strobe_cnt + 1;
    end
    if (rst && !ready) ready_lo_cnt <= ready_lo_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] last_rd   = 32'h0;
  int          n_checks  = 0;
  int          n_pass    = 0;
  int          stall_mdl = 0;
  int          acc_mdl   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference address map: half-word index of the low half of the word.
  function automatic logic [AW-1:0] lo_addr(input logic [31:0] a);
    logic [31:0] d;
    longint unsigned wi;
    d  = a - 32'(OFF);
    wi = longint'(d >> 2) % (longint'(1) << (AW - 1));
    return AW'(wi * 2);
  endfunction

  // ---------------- driver ----------------
  task automatic do_access(input bit r, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input bit hold);
    logic [AW-1:0] lo, hi;
    logic          ph_hi;
    lo = lo_addr(a);
    hi = lo + AW'(1);
    @(negedge clk);
    if (!(mem_r_en | mem_w_en)) check("idle_ready", 32'(ready), 32'd1);
    mem_r_en = r;
    mem_w_en = w;
    address  = a;
    wdata    = d;
    if (!w) begin
      exp_q.push_back({exp_mem[hi], exp_mem[lo]});
    end else begin
      exp_mem[lo] = d[15:0];
      exp_mem[hi] = d[31:16];
    end
    #1;
    check("req_ready", 32'(ready), 32'd0);
    stall_mdl++;
    for (int c = 1; c <= 2 * W; c++) begin
      @(negedge clk);
      ph_hi = (c > W);
      stall_mdl++;
      check("busy_ready", 32'(ready), 32'd0);
      check("sram_addr", 32'(sram_addr), 32'(ph_hi ? hi : lo));
      if (w) begin
        check("wr_we_n", 32'(sram_we_n), 32'd0);
        check("wr_oe_n", 32'(sram_oe_n), 32'd1);
        check("wr_data", 32'(sram_wdata), 32'(ph_hi ? d[31:16] : d[15:0]));
      end else begin
        check("rd_we_n", 32'(sram_we_n), 32'd1);
        check("rd_oe_n", 32'(sram_oe_n), 32'd0);
      end
      address = {$urandom} & 32'hFFFF_FFFC;
      wdata   = $urandom;
    end
    @(negedge clk);
    check("done_ready", 32'(ready), 32'd1);
    check("done_we_n", 32'(sram_we_n), 32'd1);
    check("done_oe_n", 32'(sram_oe_n), 32'd1);
    if (!w) last_rd = exp_q.pop_front();
    check("rdata", rdata, last_rd);
    acc_mdl++;
    if (!hold) begin
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind, s0, lo0;
    logic [31:0] a;
    rst = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b1;
    address = 32'h408; wdata = $urandom;

    repeat (3) @(negedge clk);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_wdata", 32'(sram_wdata), 32'd0);
    mem_w_en = 1'b0;
    #1 check("rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Directed write then read of the same word.
    do_access(1'b0, 1'b1, 32'h408, 32'hDEADBEEF, 1'b0);
    check("dev_lo", 32'(dev_mem[4]), 32'hBEEF);
    check("dev_hi", 32'(dev_mem[5]), 32'hDEAD);
    do_access(1'b1, 1'b0, 32'h408, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    check("rd_held", rdata, 32'hDEADBEEF);

    // Back-to-back reads with the request held through DONE.
    s0 = ready_lo_cnt;
    do_access(1'b1, 1'b0, 32'h408, 32'h0, 1'b1);
    do_access(1'b1, 1'b0, 32'h408, 32'h0, 1'b0);
    @(negedge clk);
    check("b2b_stall", 32'(ready_lo_cnt - s0), 32'(2 * (2 * W + 1)));

    // Write wins over read; rdata untouched.
    do_access(1'b1, 1'b1, 32'h40C, 32'h12345678, 1'b0);
    do_access(1'b1, 1'b0, 32'h40C, 32'h0, 1'b0);

    // Address wrap below the offset and above the SRAM range.
    do_access(1'b0, 1'b1, 32'h0, 32'hA5A55A5A, 1'b0);
    do_access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    do_access(1'b0, 1'b1, 32'h400 + (32'h1 << (AW + 1)), 32'hC0FFEE11, 1'b0);
    do_access(1'b1, 1'b0, 32'h400, 32'h0, 1'b0);

    // Randomized mix.
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) a = {$urandom} & 32'hFFFF_FFFC;
      else a = 32'h400 + 32'(4 * $urandom_range(0, 7));
      do_access(kind != 1, kind != 0, a, $urandom, (i != 23) && ($urandom_range(0, 1) == 1));
    end

`ifdef SRAM_CTRL_STATS_EN
    @(negedge clk);
    check("stats_stall", stall_cycles, 32'(stall_mdl));
    check("stats_acc", 32'(access_count), 32'(acc_mdl & 16'hFFFF));
`endif

    // Reset during the HIGH phase of a write.
    @(negedge clk);
    mem_w_en = 1'b1; address = 32'h420; wdata = 32'h11112222;
    repeat (W + 1) @(negedge clk);
    check("mid_we_n", 32'(sram_we_n), 32'd0);
    lo0 = 32'(lo_addr(32'h420));
    check("mid_addr", 32'(sram_addr), 32'(lo0 + 1));
    rst = 1'b0; mem_w_en = 1'b0;
    @(negedge clk);
    check("mrst_we_n", 32'(sram_we_n), 32'd1);
    check("mrst_oe_n", 32'(sram_oe_n), 32'd1);
    check("mrst_state", 32'(dut.state_q), 32'd0);
    check("mrst_ready", 32'(ready), 32'd1);
    check("mrst_rdata", rdata, 32'd0);
    s0 = strobe_cnt;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("mrst_strobes", 32'(strobe_cnt), 32'(s0));
    last_rd = 32'h0;

`ifdef SRAM_CTRL_STATS_EN
    check("stats_rst_stall", stall_cycles, 32'd0);
    check("stats_rst_acc", 32'(access_count), 32'd0);
    do_access(1'b0, 1'b1, 32'h410, 32'h01020304, 1'b0);
    do_access(1'b1, 1'b0, 32'h410, 32'h0, 1'b0);
    @(negedge clk);
    check("stats_two_stall", stall_cycles, 32'd10);
    check("stats_two_acc", 32'(access_count), 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
